ycbcr444_to_422: RTL and testbench

- Consumes the 8-bit YCbCr 4:4:4 stream produced by the RGB-to-YCbCr converter, using the same vs/hs/de timing.
- Produces a 16-bit YCbCr 4:2:2 stream for the downstream video output and packer stages:
  - luma on every pixel;
  - chroma subsampled by pixel-pair averaging, with Cb and Cr alternating per pixel.
- Fixed 2-clock latency; sync signals are delayed to match.

---
 rtl/ycbcr444_to_422_if.sv | 31 +++
 rtl/ycbcr444_to_422.sv | 180 ++++++++++++++++++
 tb/tb_ycbcr444_to_422.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr444_to_422_if.sv
// Video stream bundle for the 4:4:4 to 4:2:2 chroma subsampler.
// Inputs are the 8-bit 4:4:4 pixel stream with vs/hs/de timing.
// Outputs are the 4:2:2 stream: luma plus interleaved chroma,
// with the timing delayed to match.
interface ycbcr444_to_422_if;
    logic       vs_in;
    logic       hs_in;
    logic       de_in;
    logic [7:0] y_in;
    logic [7:0] cb_in;
    logic [7:0] cr_in;

    logic       vs_out;
    logic       hs_out;
    logic       de_out;
    logic [7:0] y_out;
    logic [7:0] c_out;
    logic       odd_run;

    // Stream source: drives the 4:4:4 pixels and observes the 4:2:2 result.
    modport master (
        output vs_in, hs_in, de_in, y_in, cb_in, cr_in,
        input  vs_out, hs_out, de_out, y_out, c_out, odd_run
    );

    // Subsampler side of the bundle.
    modport slave (
        input  vs_in, hs_in, de_in, y_in, cb_in, cr_in,
        output vs_out, hs_out, de_out, y_out, c_out, odd_run
    );
endinterface

// File: rtl/ycbcr444_to_422.sv
// YCbCr 4:4:4 -> 4:2:2 chroma subsampler.
// Luma passes through on every pixel. Chroma is averaged over each
// pixel pair; the pair's two averages go out alternately, one per pixel.
// The latency is a fixed 2 clocks, and vs/hs/de are delayed to match.
// A run that ends on an unpaired pixel sends out that pixel's own chroma
// and pulses odd_run on the run's last output cycle.
//
// Phase FSM:
//   state | meaning
//   PH_P0 | the next accepted pixel is the first of a pair (also idle)
//   PH_P1 | the next accepted pixel is the second of a pair
module ycbcr444_to_422 #(
    parameter int unsigned CB_FIRST = 1,
    parameter int unsigned ROUND    = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    ycbcr444_to_422_if.slave vid
);
    typedef enum logic {
        PH_P0 = 1'b0,
        PH_P1 = 1'b1
    } phase_e;

    localparam logic [8:0] RND    = (ROUND != 0) ? 9'd1 : 9'd0;
    localparam bit         CB_SEL = (CB_FIRST != 0);

    phase_e     phase_q;
    phase_e     phase_nxt;

    // After a reset, any run already in progress is ignored until de_in
    // has gone low once. This makes sure that pairing always restarts on
    // a real run start.
    logic       armed_q;
    logic       de_eff;

    logic [7:0] s1_y;
    logic [7:0] s1_cb;
    logic [7:0] s1_cr;
    logic       s1_phase;
    logic       s1_de;

    logic [1:0] vs_sr;
    logic [1:0] hs_sr;
    logic       de_q2;

    logic [8:0] cb_sum;
    logic [8:0] cr_sum;
    logic [7:0] cb_avg;
    logic [7:0] cr_avg;

    logic [7:0] y_q;
    logic [7:0] c_q;
    logic [7:0] hold_q;
    logic       odd_q;
    logic [7:0] y_nxt;
    logic [7:0] c_nxt;
    logic [7:0] hold_nxt;
    logic       odd_nxt;

    assign de_eff = vid.de_in & armed_q;

    // Arm pairing on the first de_in-low cycle seen after reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            armed_q <= 1'b0;
        end else if (!vid.de_in) begin
            armed_q <= 1'b1;
        end
    end

    // Phase state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            phase_q <= PH_P0;
        end else begin
            phase_q <= phase_nxt;
        end
    end

    // Phase toggles per accepted pixel; any de gap returns it to P0.
    always_comb begin
        phase_nxt = PH_P0;
        if (de_eff) begin
            phase_nxt = (phase_q == PH_P0) ? PH_P1 : PH_P0;
        end
    end

    // Stage 1: capture the pixel and its pair position; zero when idle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_y     <= 8'd0;
            s1_cb    <= 8'd0;
            s1_cr    <= 8'd0;
            s1_phase <= 1'b0;
            s1_de    <= 1'b0;
        end else if (de_eff) begin
            s1_y     <= vid.y_in;
            s1_cb    <= vid.cb_in;
            s1_cr    <= vid.cr_in;
            s1_phase <= (phase_q == PH_P1);
            s1_de    <= 1'b1;
        end else begin
            s1_y     <= 8'd0;
            s1_cb    <= 8'd0;
            s1_cr    <= 8'd0;
            s1_phase <= 1'b0;
            s1_de    <= 1'b0;
        end
    end

    // Pair averages. The partner of P0 in stage 1 is the live input.
    // With no partner, the P0 chroma is used unchanged.
    // Sums are 9 bits wide, so 255 + 255 + 1 cannot overflow.
    always_comb begin
        cb_sum = {1'b0, s1_cb} + {1'b0, vid.cb_in} + RND;
        cr_sum = {1'b0, s1_cr} + {1'b0, vid.cr_in} + RND;
        cb_avg = s1_cb;
        cr_avg = s1_cr;
        if (de_eff) begin
            cb_avg = cb_sum[8:1];
            cr_avg = cr_sum[8:1];
        end
    end

    // Stage 2 next values. P0 sends one average and parks the other,
    // and P1 then sends the parked one.
    always_comb begin
        y_nxt    = 8'd0;
        c_nxt    = 8'd0;
        hold_nxt = hold_q;
        odd_nxt  = 1'b0;
        if (s1_de) begin
            y_nxt = s1_y;
            if (!s1_phase) begin
                c_nxt    = CB_SEL ? cb_avg : cr_avg;
                hold_nxt = CB_SEL ? cr_avg : cb_avg;
                odd_nxt  = ~de_eff;
            end else begin
                c_nxt = hold_q;
            end
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            y_q    <= 8'd0;
            c_q    <= 8'd0;
            hold_q <= 8'd0;
            odd_q  <= 1'b0;
        end else begin
            y_q    <= y_nxt;
            c_q    <= c_nxt;
            hold_q <= hold_nxt;
            odd_q  <= odd_nxt;
        end
    end

    // Two-stage timing delay. de follows the gated enable, so pixels
    // that are dropped after a reset never show up as active output.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vs_sr <= 2'b00;
            hs_sr <= 2'b00;
            de_q2 <= 1'b0;
        end else begin
            vs_sr <= {vs_sr[0], vid.vs_in};
            hs_sr <= {hs_sr[0], vid.hs_in};
            de_q2 <= s1_de;
        end
    end

    assign vid.vs_out  = vs_sr[1];
    assign vid.hs_out  = hs_sr[1];
    assign vid.de_out  = de_q2;
    assign vid.y_out   = y_q;
    assign vid.c_out   = c_q;
    assign vid.odd_run = odd_q;
endmodule

// File: tb/tb_ycbcr444_to_422.sv
// Bench for ycbcr444_to_422. Four instances cover every CB_FIRST/ROUND
// combination and share one input stream. A pair-level reference model
// pushes the expected outputs into one queue per instance. A monitor on
// the falling edge pops from these queues whenever de_out is high.
module tb_ycbcr444_to_422;
    localparam int NCFG = 4;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] c;
        logic       odd;
    } exp_t;

    logic       clk;
    logic       rst_b;
    logic       vs_i;
    logic       hs_i;
    logic       de_i;
    logic [7:0] y_i;
    logic [7:0] cb_i;
    logic [7:0] cr_i;

    logic       vs_o  [NCFG];
    logic       hs_o  [NCFG];
    logic       de_o  [NCFG];
    logic       odd_o [NCFG];
    logic [7:0] y_o   [NCFG];
    logic [7:0] c_o   [NCFG];

    exp_t       exp_q [NCFG][$];

    int         n_checks;
    int         n_fail;

    bit         armed_m;
    bit         have_p0;
    logic [7:0] p0_y;
    logic [7:0] p0_cb;
    logic [7:0] p0_cr;
    logic [2:0] vs_h;
    logic [2:0] hs_h;

    // cfg0: CB_FIRST=1 ROUND=1, cfg1: CB_FIRST=1 ROUND=0,
    // cfg2: CB_FIRST=0 ROUND=1, cfg3: CB_FIRST=0 ROUND=0
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        ycbcr444_to_422_if vif ();
        assign vif.vs_in = vs_i;
        assign vif.hs_in = hs_i;
        assign vif.de_in = de_i;
        assign vif.y_in  = y_i;
        assign vif.cb_in = cb_i;
        assign vif.cr_in = cr_i;

        ycbcr444_to_422 #(
            .CB_FIRST((g < 2) ? 1 : 0),
            .ROUND   ((g % 2 == 0) ? 1 : 0)
        ) dut (
            .clk   (clk),
            .rst_b (rst_b),
            .vid   (vif.slave)
        );

        assign vs_o[g]  = vif.vs_out;
        assign hs_o[g]  = vif.hs_out;
        assign de_o[g]  = vif.de_out;
        assign odd_o[g] = vif.odd_run;
        assign y_o[g]   = vif.y_out;
        assign c_o[g]   = vif.c_out;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cbf_of(int k);
        return k < 2;
    endfunction

    function automatic int rnd_of(int k);
        return (k % 2 == 0) ? 1 : 0;
    endfunction

    function automatic logic [7:0] avg(int k, logic [7:0] a, logic [7:0] b);
        int s;
        s = int'(a) + int'(b) + rnd_of(k);
        return 8'(s / 2);
    endfunction

    function automatic exp_t mk(logic [7:0] y, logic [7:0] c, logic odd);
        exp_t e;
        e.y   = y;
        e.c   = c;
        e.odd = odd;
        return e;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cfg%0d: got %0d, expected %0d (t=%0t)", nm, k, act, req, $time);
        end
    endtask

    // Reference model: pixels are grouped into pairs within a de run.
    // A pair yields its two chroma averages, one on each pixel. A pixel
    // left unpaired at the end of a run yields its own chroma and an
    // odd flag.
    task automatic model_step(input bit de, input logic [7:0] y,
                              input logic [7:0] cb, input logic [7:0] cr);
        logic [7:0] a_cb;
        logic [7:0] a_cr;
        if (!armed_m) begin
            if (!de) armed_m = 1'b1;
        end else if (de) begin
            if (have_p0) begin
                for (int k = 0; k < NCFG; k++) begin
                    a_cb = avg(k, p0_cb, cb);
                    a_cr = avg(k, p0_cr, cr);
                    exp_q[k].push_back(mk(p0_y, cbf_of(k) ? a_cb : a_cr, 1'b0));
                    exp_q[k].push_back(mk(y, cbf_of(k) ? a_cr : a_cb, 1'b0));
                end
                have_p0 = 1'b0;
            end else begin
                p0_y    = y;
                p0_cb   = cb;
                p0_cr   = cr;
                have_p0 = 1'b1;
            end
        end else begin
            if (have_p0) begin
                for (int k = 0; k < NCFG; k++)
                    exp_q[k].push_back(mk(p0_y, cbf_of(k) ? p0_cb : p0_cr, 1'b1));
            end
            have_p0 = 1'b0;
        end
    endtask

    // One input cycle. With rst_v=0, reset is held low for the cycle:
    // everything in flight is discarded and the outputs read zero.
    task automatic drive(input bit rst_v, input bit de, input logic [7:0] y,
                         input logic [7:0] cb, input logic [7:0] cr,
                         input bit vs, input bit hs);
        @(posedge clk);
        #1;
        rst_b = rst_v;
        de_i  = de;
        y_i   = y;
        cb_i  = cb;
        cr_i  = cr;
        vs_i  = vs;
        hs_i  = hs;
        if (!rst_v) begin
            for (int k = 0; k < NCFG; k++) exp_q[k].delete();
            armed_m = 1'b0;
            have_p0 = 1'b0;
            vs_h    = 3'b000;
            hs_h    = 3'b000;
        end else begin
            vs_h = {vs_h[1:0], vs};
            hs_h = {hs_h[1:0], hs};
            model_step(de, y, cb, cr);
        end
    endtask

    task automatic px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        drive(1'b1, 1'b1, y, cb, cr, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    endtask

    // Monitor: compare timing each cycle, and pixels whenever de_out is high.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NCFG; k++) begin
            chk("vs_out", k, 32'(vs_o[k]), 32'(vs_h[2]));
            chk("hs_out", k, 32'(hs_o[k]), 32'(hs_h[2]));
            if (de_o[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk("de_out_unexpected", k, 32'(de_o[k]), 32'd0);
                end else begin
                    e = exp_q[k].pop_front();
                    chk("y_out", k, 32'(y_o[k]), 32'(e.y));
                    chk("c_out", k, 32'(c_o[k]), 32'(e.c));
                    chk("odd_run", k, 32'(odd_o[k]), 32'(e.odd));
                end
            end else begin
                chk("idle_zero", k, {15'd0, y_o[k], c_o[k], odd_o[k]}, 32'd0);
            end
        end
    end

    initial begin
        int len;
        int gap;
        int rst_at;
        n_checks = 0;
        n_fail   = 0;
        armed_m  = 1'b0;
        have_p0  = 1'b0;
        p0_y     = 8'd0;
        p0_cb    = 8'd0;
        p0_cr    = 8'd0;
        vs_h     = 3'b000;
        hs_h     = 3'b000;
        rst_b    = 1'b0;
        vs_i     = 1'b0;
        hs_i     = 1'b0;
        de_i     = 1'b0;
        y_i      = 8'd0;
        cb_i     = 8'd0;
        cr_i     = 8'd0;

        // Reset held for 5 clocks with random inputs, then released idle.
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom));
        idle(4);

        // Even run: cfg0 expects c=101,61,125,128 and cfg1 expects 100,61,125,127.
        px(8'd10, 8'd100, 8'd60);
        px(8'd20, 8'd101, 8'd62);
        px(8'd30, 8'd200, 8'd0);
        px(8'd40, 8'd50,  8'd255);
        idle(3);

        // Odd run of 3: cfg0 expects c=15,35,90 with odd_run on the 3rd pixel.
        px(8'd5, 8'd10, 8'd30);
        px(8'd6, 8'd20, 8'd40);
        px(8'd7, 8'd90, 8'd77);
        idle(3);

        // CB_FIRST=0 (cfg2) expects c=255,128.
        px(8'd1, 8'd0,   8'd255);
        px(8'd2, 8'd255, 8'd255);
        idle(2);

        // Single-pixel run.
        px(8'd99, 8'd44, 8'd211);
        idle(1);

        // Two-pixel run, 1-cycle gap, then 5-pixel run reset on its 3rd pixel.
        px(8'd11, 8'd1, 8'd2);
        px(8'd12, 8'd3, 8'd4);
        idle(1);
        px(8'd21, 8'd50, 8'd60);
        px(8'd22, 8'd70, 8'd80);
        drive(1'b0, 1'b1, 8'd23, 8'd90, 8'd100, 1'b0, 1'b0);
        px(8'd24, 8'd110, 8'd120);
        px(8'd25, 8'd130, 8'd140);
        idle(2);
        px(8'd31, 8'd7, 8'd9);
        px(8'd32, 8'd8, 8'd10);
        idle(3);

        // Random runs and gaps with random sync, plus occasional mid-run resets.
        for (int r = 0; r < 300; r++) begin
            len    = $urandom_range(1, 9);
            gap    = $urandom_range(1, 3);
            rst_at = -1;
            if ($urandom_range(0, 29) == 0) rst_at = $urandom_range(0, len - 1);
            for (int i = 0; i < len; i++)
                drive(i != rst_at, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom));
            for (int i = 0; i < gap; i++)
                drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom));
        end

        idle(5);
        for (int k = 0; k < NCFG; k++)
            chk("drain", k, 32'(exp_q[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
